// File: rtl/mux4_rr_sched.sv
// Four-requester round-robin scheduler with a registered valid/ready output stage.
// Define MUX4_RR_SCHED_PRIO0_EN to give requester 0 absolute priority over the rotating others.
module mux4_rr_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic [3:0]       grant,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [3:0]       ack,
    output logic [7:0]       xfer_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t           state_reg;
    logic [1:0]       sel_reg;
    logic [1:0]       last_reg;
    logic [3:0]       grant_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [3:0]       ack_reg;
    logic [7:0]       xfer_cnt_reg;

    logic [WIDTH-1:0] a_arr [4];
    logic [1:0]       base;
    logic [3:0]       rr_req;
    logic [1:0]       cand_idx [4];
    logic [3:0]       cand_hit;
    logic [1:0]       pick_next;
    logic [3:0]       pick_onehot;
    logic             accept;

    assign a_arr[0] = a0;
    assign a_arr[1] = a1;
    assign a_arr[2] = a2;
    assign a_arr[3] = a3;

    // On acceptance the granted index becomes the new "last", so rotate from sel directly.
    assign base   = (state_reg == OFFER) ? sel_reg : last_reg;
    assign accept = (state_reg == OFFER) && out_ready;

`ifdef MUX4_RR_SCHED_PRIO0_EN
    assign rr_req = req & 4'b1110;
`else
    assign rr_req = req;
`endif

    // Candidate gi is the requester gi+1 positions after base; base itself comes last.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_scan
            assign cand_idx[gi] = base + 2'(gi + 1);
            assign cand_hit[gi] = rr_req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        pick_next = base;
        for (int i = 3; i >= 0; i--) begin
            if (cand_hit[i]) begin
                pick_next = cand_idx[i];
            end
        end
`ifdef MUX4_RR_SCHED_PRIO0_EN
        if (req[0]) begin
            pick_next = 2'd0;
        end
`endif
    end

    assign pick_onehot = 4'b0001 << pick_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            sel_reg      <= 2'd0;
            last_reg     <= 2'd3;
            grant_reg    <= 4'b0000;
            out_data_reg <= '0;
            ack_reg      <= 4'b0000;
            xfer_cnt_reg <= 8'd0;
        end else begin
            ack_reg <= 4'b0000;
            case (state_reg)
                IDLE: begin
                    if (req != 4'b0000) begin
                        state_reg    <= OFFER;
                        sel_reg      <= pick_next;
                        grant_reg    <= pick_onehot;
                        out_data_reg <= a_arr[pick_next];
                    end
                end
                OFFER: begin
                    if (accept) begin
                        last_reg     <= sel_reg;
                        xfer_cnt_reg <= xfer_cnt_reg + 8'd1;
                        ack_reg      <= grant_reg;
                        if (req != 4'b0000) begin
                            sel_reg      <= pick_next;
                            grant_reg    <= pick_onehot;
                            out_data_reg <= a_arr[pick_next];
                        end else begin
                            state_reg <= IDLE;
                            grant_reg <= 4'b0000;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign sel       = sel_reg;
    assign grant     = grant_reg;
    assign out_data  = out_data_reg;
    assign out_valid = (state_reg == OFFER);
    assign ack       = ack_reg;
    assign xfer_cnt  = xfer_cnt_reg;

endmodule
